fetch_decode_queue: RTL and testbench

- Sits directly downstream of the fetch stage.
- Takes each fetched PC/PC+4 pair, issues the instruction-memory read and pairs the returned instruction word with its PC.
- Buffers the results in a small FIFO and presents them to decode with a valid/ready handshake.
- Back-pressures fetch when it cannot accept a PC and discards in-flight work on a pipeline flush (branch/jump redirect).

---
 rtl/fetch_decode_queue_if.sv | 33 +++
 rtl/fetch_decode_queue.sv | 122 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_queue_if.sv
// Signal bundle between fetch, instruction memory, the fetch/decode queue and decode.
// The queue itself takes the slave view.
interface fetch_decode_queue_if;
  logic [31:0] pc_in;
  logic [31:0] pc_plus4_in;
  logic        pc_valid_in;
  logic        fetch_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;

  modport master (
    output pc_in, pc_plus4_in, pc_valid_in, imem_gnt, imem_rvalid, imem_rdata,
           flush, dec_ready,
    input  fetch_stall, imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
           dec_pc_plus4
  );

  modport slave (
    input  pc_in, pc_plus4_in, pc_valid_in, imem_gnt, imem_rvalid, imem_rdata,
           flush, dec_ready,
    output fetch_stall, imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
           dec_pc_plus4
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Issues one instruction-memory read per accepted PC, pairs the returned word with its PC
// and buffers the results in a small FIFO that decode drains with valid/ready.
module fetch_decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  fetch_decode_queue_if.slave bus
);
  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   pend_pc4_q, pend_pc4_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc4_q   [DEPTH];

  logic outstanding, room, issue, push, pop, head_valid;

  // The in-flight request already owns a FIFO slot, so a push can never overflow.
  assign outstanding = (state_q == WAIT_GNT) || (state_q == WAIT_RESP);
  assign room        = (count_q + CW'(outstanding)) < DEPTH_C;
  assign issue       = rst && bus.pc_valid_in && !bus.flush && room &&
                       ((state_q == IDLE) || ((state_q == WAIT_RESP) && bus.imem_rvalid));
  assign push        = (state_q == WAIT_RESP) && bus.imem_rvalid && !bus.flush;
  assign head_valid  = (count_q != '0);
  assign pop         = head_valid && bus.dec_ready && !bus.flush;

  assign bus.dec_valid    = head_valid;
  assign bus.dec_instr    = head_valid ? instr_q[rd_ptr_q] : NOP;
  assign bus.dec_pc       = head_valid ? pc_q[rd_ptr_q]    : 32'h0;
  assign bus.dec_pc_plus4 = head_valid ? pc4_q[rd_ptr_q]   : 32'h0;

  always_comb begin
    state_d         = state_q;
    pend_pc_d       = pend_pc_q;
    pend_pc4_d      = pend_pc4_q;
    bus.imem_req    = 1'b0;
    bus.imem_addr   = 32'h0;
    bus.fetch_stall = 1'b1;
    unique case (state_q)
      IDLE: state_d = IDLE;
      WAIT_GNT: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = {pend_pc_q[31:2], 2'b00};
        if (bus.flush) begin
          // A grant in the same cycle still owes us a response that must be dropped.
          state_d = bus.imem_gnt ? DRAIN : IDLE;
        end else if (bus.imem_gnt) begin
          bus.fetch_stall = 1'b0;
          state_d         = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (bus.flush) begin
          state_d = bus.imem_rvalid ? IDLE : DRAIN;
        end else if (bus.imem_rvalid) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      bus.imem_req    = 1'b1;
      bus.imem_addr   = {bus.pc_in[31:2], 2'b00};
      pend_pc_d       = bus.pc_in;
      pend_pc4_d      = bus.pc_plus4_in;
      bus.fetch_stall = !bus.imem_gnt;
      state_d         = bus.imem_gnt ? WAIT_RESP : WAIT_GNT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pend_pc_q  <= 32'h0;
      pend_pc4_q <= 32'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      pend_pc4_q <= pend_pc4_d;
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= bus.imem_rdata;
      pc_q[wr_ptr_q]    <= pend_pc_q;
      pc4_q[wr_ptr_q]   <= pend_pc4_q;
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for the fetch/decode queue: directed vector table, hand sequences for
// back-pressure, wrap and reset, then random traffic against a queue-based model.
module tb_fetch_decode_queue;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic        H     = 1'b1;
  localparam logic        L     = 1'b0;
  localparam int          NVEC  = 24;

  logic clk = 1'b0;
  logic rst;

  fetch_decode_queue_if bus ();

  fetch_decode_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        fl;
    logic        rdy;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  vec_t vt [NVEC];

  // Wrap-sequence scoreboard state
  logic [31:0] nxt_pc, exp_pc, resp_pc;
  logic        resp_due, acc;
  int          pops;

  // Reference model: the queue contents plus the single request the block may own
  ent_t        mq [$];
  logic        req_pending, resp_owed, keep;
  logic [31:0] pend_pc, pend_pc4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic fl, input logic rdy);
    bus.pc_valid_in = pv;
    bus.pc_in       = pc;
    bus.pc_plus4_in = pc + 32'd4;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.flush       = fl;
    bus.dec_ready   = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic stall, input logic req,
                            input logic [31:0] addr, input logic dv, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] pc4);
    chk({tag, ".fetch_stall"}, 32'(bus.fetch_stall), 32'(stall));
    chk({tag, ".imem_req"}, 32'(bus.imem_req), 32'(req));
    if (req) chk({tag, ".imem_addr"}, bus.imem_addr, addr);
    chk({tag, ".dec_valid"}, 32'(bus.dec_valid), 32'(dv));
    chk({tag, ".dec_instr"}, bus.dec_instr, instr);
    chk({tag, ".dec_pc"}, bus.dec_pc, pc);
    chk({tag, ".dec_pc_plus4"}, bus.dec_pc_plus4, pc4);
  endtask

  initial begin
    // pv  pc            gnt rv  rdata          fl rdy | stall req addr      dv  instr          pc            pc4
    vt[0]  = '{H, 32'h00, H, L, 32'h0,        L, L,   L, H, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[1]  = '{L, 32'h00, L, H, 32'h00500093, L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[2]  = '{L, 32'h00, L, L, 32'h0,        L, H,   H, L, 32'h00, H, 32'h00500093,  32'h0,  32'h4};
    vt[3]  = '{H, 32'h10, L, L, 32'h0,        L, L,   H, H, 32'h10, L, NOP,           32'h0,  32'h0};
    vt[4]  = '{H, 32'h10, L, L, 32'h0,        L, L,   H, H, 32'h10, L, NOP,           32'h0,  32'h0};
    vt[5]  = '{H, 32'h10, L, L, 32'h0,        L, L,   H, H, 32'h10, L, NOP,           32'h0,  32'h0};
    vt[6]  = '{H, 32'h10, H, L, 32'h0,        L, L,   L, H, 32'h10, L, NOP,           32'h0,  32'h0};
    vt[7]  = '{L, 32'h00, L, H, 32'h11111111, L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[8]  = '{H, 32'h14, H, L, 32'h0,        L, L,   L, H, 32'h14, H, 32'h11111111,  32'h10, 32'h14};
    vt[9]  = '{L, 32'h00, L, L, 32'h0,        H, L,   H, L, 32'h00, H, 32'h11111111,  32'h10, 32'h14};
    vt[10] = '{H, 32'h40, H, L, 32'h0,        L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[11] = '{H, 32'h40, H, H, 32'hDEADBEEF, L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[12] = '{H, 32'h40, H, L, 32'h0,        L, L,   L, H, 32'h40, L, NOP,           32'h0,  32'h0};
    vt[13] = '{L, 32'h00, L, H, 32'h22222222, L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[14] = '{L, 32'h00, L, L, 32'h0,        L, H,   H, L, 32'h00, H, 32'h22222222,  32'h40, 32'h44};
    vt[15] = '{L, 32'h00, L, L, 32'h0,        L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[16] = '{H, 32'h80, L, L, 32'h0,        L, L,   H, H, 32'h80, L, NOP,           32'h0,  32'h0};
    vt[17] = '{H, 32'h80, L, L, 32'h0,        H, L,   H, H, 32'h80, L, NOP,           32'h0,  32'h0};
    vt[18] = '{L, 32'h00, L, L, 32'h0,        L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[19] = '{H, 32'h84, L, L, 32'h0,        L, L,   H, H, 32'h84, L, NOP,           32'h0,  32'h0};
    vt[20] = '{H, 32'h84, H, L, 32'h0,        H, L,   H, H, 32'h84, L, NOP,           32'h0,  32'h0};
    vt[21] = '{H, 32'h88, H, L, 32'h0,        L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[22] = '{L, 32'h00, L, H, 32'h33333333, L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};
    vt[23] = '{L, 32'h00, L, L, 32'h0,        L, L,   H, L, 32'h00, L, NOP,           32'h0,  32'h0};

    rst = L;
    drive(L, 32'h0, L, L, 32'h0, L, L);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", H, L, 32'h0, L, NOP, 32'h0, 32'h0);
    rst = H;

    for (int i = 0; i < NVEC; i++) begin
      drive(vt[i].pv, vt[i].pc, vt[i].gnt, vt[i].rv, vt[i].rd, vt[i].fl, vt[i].rdy);
      expect_out($sformatf("vec%0d", i), vt[i].e_stall, vt[i].e_req, vt[i].e_addr,
                 vt[i].e_dv, vt[i].e_instr, vt[i].e_pc, vt[i].e_pc4);
      $display("vec %0d pc=%h stall=%b req=%b dv=%b instr=%h", i, vt[i].pc,
               bus.fetch_stall, bus.imem_req, bus.dec_valid, bus.dec_instr);
      tick();
    end

    // Back-pressure: two entries fill the queue, the third PC waits for a pop
    drive(H, 32'h0, H, L, 32'h0, L, L);        expect_out("bp0", L, H, 32'h0, L, NOP, 32'h0, 32'h0); tick();
    drive(H, 32'h4, H, H, 32'hA0000000, L, L); expect_out("bp1", L, H, 32'h4, L, NOP, 32'h0, 32'h0); tick();
    drive(H, 32'h8, H, H, 32'hA0000004, L, L); expect_out("bp2", H, L, 32'h0, H, 32'hA0000000, 32'h0, 32'h4); tick();
    drive(H, 32'h8, H, L, 32'h0, L, L);        expect_out("bp3", H, L, 32'h0, H, 32'hA0000000, 32'h0, 32'h4); tick();
    drive(H, 32'h8, H, L, 32'h0, L, L);        expect_out("bp4", H, L, 32'h0, H, 32'hA0000000, 32'h0, 32'h4); tick();
    drive(H, 32'h8, H, L, 32'h0, L, H);        expect_out("bp5", H, L, 32'h0, H, 32'hA0000000, 32'h0, 32'h4); tick();
    drive(H, 32'h8, H, L, 32'h0, L, L);        expect_out("bp6", L, H, 32'h8, H, 32'hA0000004, 32'h4, 32'h8); tick();
    drive(L, 32'h0, L, H, 32'hA0000008, L, L); expect_out("bp7", H, L, 32'h0, H, 32'hA0000004, 32'h4, 32'h8); tick();
    drive(L, 32'h0, L, L, 32'h0, L, H);        expect_out("bp8", H, L, 32'h0, H, 32'hA0000004, 32'h4, 32'h8); tick();
    drive(L, 32'h0, L, L, 32'h0, L, H);        expect_out("bp9", H, L, 32'h0, H, 32'hA0000008, 32'h8, 32'hC); tick();
    drive(L, 32'h0, L, L, 32'h0, L, L);        expect_out("bp10", H, L, 32'h0, L, NOP, 32'h0, 32'h0); tick();
    $display("backpressure sequence done");

    // Streaming with decode always ready: pointers wrap over five entries
    nxt_pc = 32'h0; exp_pc = 32'h0; resp_pc = 32'h0; resp_due = L; pops = 0;
    for (int cyc = 0; cyc < 40 && pops < 5; cyc++) begin
      drive(nxt_pc <= 32'h10, nxt_pc, H, resp_due, 32'hC0000000 | resp_pc, L, H);
      if (bus.dec_valid) begin
        chk("wrap.dec_pc", bus.dec_pc, exp_pc);
        chk("wrap.dec_instr", bus.dec_instr, 32'hC0000000 | exp_pc);
        $display("wrap pop pc=%h instr=%h", bus.dec_pc, bus.dec_instr);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      acc = (nxt_pc <= 32'h10) && !bus.fetch_stall;
      if (acc) begin
        resp_pc = nxt_pc;
        nxt_pc  = nxt_pc + 32'd4;
      end
      resp_due = acc;
      tick();
    end
    chk("wrap.pops", 32'(pops), 32'd5);

    // Reset pulsed while a response is owed and one entry is queued
    drive(H, 32'h20, H, L, 32'h0, L, L); tick();
    drive(L, 32'h0, L, H, 32'h55, L, L); tick();
    drive(H, 32'h24, H, L, 32'h0, L, L);
    expect_out("rs.pre", L, H, 32'h24, H, 32'h55, 32'h20, 32'h24); tick();
    rst = L;
    drive(H, 32'h28, H, L, 32'h0, L, L);
    expect_out("rs.low", H, L, 32'h0, L, NOP, 32'h0, 32'h0); tick();
    rst = H;
    drive(L, 32'h0, L, H, 32'hBAD, L, L);
    expect_out("rs.stray", H, L, 32'h0, L, NOP, 32'h0, 32'h0); tick();
    drive(L, 32'h0, L, L, 32'h0, L, L);
    expect_out("rs.after", H, L, 32'h0, L, NOP, 32'h0, 32'h0); tick();
    $display("reset sequence done");

    // Random traffic against the reference model
    mq.delete();
    req_pending = L; resp_owed = L; keep = L; pend_pc = 32'h0; pend_pc4 = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      logic        r_pv, r_gnt, r_rv, r_fl, r_rdy;
      logic [31:0] r_pc, r_rd;
      logic        busy, room_m, idle_m, can_issue, e_req, e_dv, accepted, push_it;
      logic [31:0] e_addr, e_instr, e_pc, e_pc4;

      r_pv  = ($urandom_range(0, 3) != 0);
      r_pc  = $urandom() & 32'hFFFFFFFC;
      r_gnt = ($urandom_range(0, 2) != 0);
      r_rv  = resp_owed && ($urandom_range(0, 2) != 0);
      r_rd  = $urandom();
      r_fl  = ($urandom_range(0, 19) == 0);
      r_rdy = ($urandom_range(0, 1) != 0);
      drive(r_pv, r_pc, r_gnt, r_rv, r_rd, r_fl, r_rdy);

      e_dv    = (mq.size() != 0);
      e_instr = e_dv ? mq[0].instr : NOP;
      e_pc    = e_dv ? mq[0].pc : 32'h0;
      e_pc4   = e_dv ? mq[0].pc4 : 32'h0;
      busy      = req_pending || (resp_owed && keep);
      room_m    = (mq.size() + (busy ? 1 : 0)) < DEPTH;
      idle_m    = !req_pending && !resp_owed;
      can_issue = r_pv && !r_fl && room_m && (idle_m || (resp_owed && keep && r_rv));
      e_req     = can_issue || req_pending;
      e_addr    = req_pending ? (pend_pc & 32'hFFFFFFFC) : r_pc;
      accepted  = (can_issue && r_gnt) || (req_pending && r_gnt && !r_fl);
      expect_out($sformatf("rnd%0d", c), !accepted, e_req, e_addr, e_dv, e_instr, e_pc, e_pc4);
      if (e_dv && r_rdy && !r_fl) begin
        $display("rnd %0d pop pc=%h instr=%h", c, e_pc, e_instr);
      end

      push_it = resp_owed && keep && r_rv && !r_fl;
      if (r_fl) begin
        mq.delete();
      end else begin
        if (e_dv && r_rdy) void'(mq.pop_front());
        if (push_it) mq.push_back('{r_rd, pend_pc, pend_pc4});
      end
      if (resp_owed && r_rv) begin
        resp_owed = L;
      end else if (resp_owed && r_fl) begin
        keep = L;
      end
      if (req_pending) begin
        if (r_gnt) begin
          req_pending = L;
          resp_owed   = H;
          keep        = !r_fl;
        end else if (r_fl) begin
          req_pending = L;
        end
      end
      if (can_issue) begin
        pend_pc  = r_pc;
        pend_pc4 = r_pc + 32'd4;
        if (r_gnt) begin
          resp_owed = H;
          keep      = H;
        end else begin
          req_pending = H;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
